// File: rtl/risc_pkg.sv
// risc_pkg: shared instruction encodings, sequencer states and instruction classes
package risc_pkg;
  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_J = 2'b01;
  localparam logic [1:0] T_I = 2'b10;
  localparam logic [1:0] T_S = 2'b11;
  localparam logic [4:0] F_ANDI = 5'd0;
  localparam logic [4:0] F_ADDI = 5'd1;
  localparam logic [4:0] F_LW = 5'd2;
  localparam logic [4:0] F_SW = 5'd3;
  localparam logic [4:0] F_BEQ = 5'd4;
  localparam logic [4:0] R_MAX = 5'd3;
  localparam logic [4:0] J_MAX = 5'd2;
  localparam logic [4:0] S_MAX = 5'd3;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITE_BACK, S_HALT, S_ERROR
  } state_t;
  typedef enum logic [2:0] {
    C_JUMP, C_BRANCH, C_ALU, C_LOAD, C_STORE, C_ILLEGAL
  } cls_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational map from type/function fields to instruction class
module instr_class_decode
  import risc_pkg::*;
(
  input  logic [1:0] instruction_type,
  input  logic [4:0] function_code,
  output cls_t       cls_o
);
  always_comb begin
    cls_o = (instruction_type == T_J) ? (function_code <= J_MAX ? C_JUMP : C_ILLEGAL) :
            (instruction_type == T_I) ? (function_code == F_LW  ? C_LOAD :
                                         function_code == F_SW  ? C_STORE :
                                         function_code == F_BEQ ? C_BRANCH :
                                         function_code <= F_ADDI ? C_ALU : C_ILLEGAL) :
            (instruction_type == T_R) ? (function_code <= R_MAX ? C_ALU : C_ILLEGAL) :
                                        (function_code <= S_MAX ? C_ALU : C_ILLEGAL);
  end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle FETCH..WRITE_BACK sequencer with memory handshake,
// stop/halt handling, illegal-opcode and timeout errors, and a retired counter.
module stage_sequencer
  import risc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             instruction_type,
  input  logic [4:0]             function_code,
  input  logic                   stop_bit,
  input  logic                   mem_ready,
  output logic                   en_instruction_fetch,
  output logic                   en_instruction_decode,
  output logic                   en_execute,
  output logic                   en_memory,
  output logic                   en_write_back,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal_instr,
  output logic                   mem_timeout,
  output logic [COUNT_WIDTH-1:0] retired_count
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  state_t state_q, state_d, fin;
  cls_t cls, cls_q;
  logic stop_q, tmo_q, done;
  logic [WW-1:0] wait_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  instr_class_decode u_dec (
    .instruction_type(instruction_type),
    .function_code(function_code),
    .cls_o(cls)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cls_q     <= C_JUMP;
      stop_q    <= 1'b0;
      tmo_q     <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q  <= cls;
        stop_q <= stop_bit;
      end
      wait_q <= (state_q == S_MEMORY && state_d == S_MEMORY) ? wait_q + WW'(1) : '0;
      tmo_q  <= tmo_q | (state_q == S_MEMORY && state_d == S_ERROR);
      if (done) retired_q <= retired_q + COUNT_WIDTH'(1);
    end
  end
  // J-type completes at the DECODE edge, so its stop bit comes straight from the input
  always_comb begin
    fin = stop_q ? S_HALT : S_FETCH;
    state_d = state_q;
    done = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        done = cls == C_JUMP;
        state_d = (cls == C_JUMP) ? (stop_bit ? S_HALT : S_FETCH) :
                  (cls == C_ILLEGAL) ? S_ERROR : S_EXECUTE;
      end
      S_EXECUTE: begin
        done = cls_q == C_BRANCH;
        state_d = (cls_q == C_BRANCH) ? fin :
                  (cls_q inside {C_LOAD, C_STORE}) ? S_MEMORY : S_WRITE_BACK;
      end
      S_MEMORY: begin
        done = mem_ready && cls_q == C_STORE;
        state_d = mem_ready ? (cls_q == C_LOAD ? S_WRITE_BACK : fin) :
                  (wait_q == WW'(MEM_TIMEOUT - 1)) ? S_ERROR : S_MEMORY;
      end
      S_WRITE_BACK: begin
        done = 1'b1;
        state_d = fin;
      end
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    en_instruction_fetch  = state_q == S_FETCH;
    en_instruction_decode = state_q == S_DECODE;
    en_execute            = state_q == S_EXECUTE;
    en_memory             = state_q == S_MEMORY;
    en_write_back         = state_q == S_WRITE_BACK;
    mem_req               = state_q == S_MEMORY;
    mem_write             = state_q == S_MEMORY && cls_q == C_STORE;
    busy                  = !(state_q inside {S_IDLE, S_HALT, S_ERROR});
    halted                = state_q == S_HALT;
    illegal_instr         = state_q == S_ERROR && !tmo_q;
    mem_timeout           = state_q == S_ERROR && tmo_q;
    retired_count         = retired_q;
  end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle stage sequencer for the RISC core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITE_BACK, skipping the stages that instruction type does not need, and drives one-hot stage-enable pulses to the PC module, instruction memory, register file, ALU and data memory. It also runs the data-memory request/ready handshake with a timeout, honours the instruction stop bit, flags illegal opcodes and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEMORY waiting for mem_ready before ERROR (>=2)
COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
clock  input  1  core clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; forces IDLE
start  input  1  launch from IDLE, or resume from HALT
instruction_type  input  2  InstructionReg type field (R/J/I/S), valid during DECODE
function_code  input  5  InstructionReg function field, valid during DECODE
stop_bit  input  1  InstructionReg stop bit, valid during DECODE
mem_ready  input  1  data memory completed current access
en_instruction_fetch  output  1  high for the FETCH cycle
en_instruction_decode  output  1  high for the DECODE cycle
en_execute  output  1  high for the EXECUTE cycle
en_memory  output  1  high for every MEMORY cycle
en_write_back  output  1  high for the WRITE_BACK cycle
mem_req  output  1  data memory request, held through MEMORY
mem_write  output  1  1 = store, 0 = load; meaningful only with mem_req
busy  output  1  state not in IDLE, HALT or ERROR
halted  output  1  state == HALT
illegal_instr  output  1  state == ERROR caused by bad opcode
mem_timeout  output  1  state == ERROR caused by timeout
retired_count  output  COUNT_WIDTH  instructions completed

Behaviour:
- Reset: async. State = IDLE. All outputs 0. retired_count = 0. Latched class/stop cleared. Applies mid-instruction. A pending mem_req drops immediately.
- Moore outputs only: all outputs decode from state and internal registers. No input-to-output combinational path.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITE_BACK, HALT, ERROR.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: always -> DECODE (1 cycle).
- DECODE: at the clock edge, latch instruction_type, function_code and stop_bit, and classify:
  - J-type -> instruction complete.
  - Illegal opcode -> ERROR, set illegal_instr. The instruction does not retire.
  - All others -> EXECUTE.
- EXECUTE:
  - BEQ -> complete.
  - LW or SW -> MEMORY.
  - ALU class (R-type, S-type, ANDI, ADDI) -> WRITE_BACK.
- MEMORY handshake:
  - mem_req=1 and mem_write = (SW) for every cycle in MEMORY.
  - The wait counter resets to 0 on entry and increments each cycle mem_ready is low.
  - mem_ready high at a clock edge: LW -> WRITE_BACK; SW -> complete. mem_req drops the next cycle.
  - The counter reaches MEM_TIMEOUT-1 with mem_ready low -> ERROR, set mem_timeout.
  - mem_ready high on the timeout cycle: ready wins.
- WRITE_BACK: -> complete.
- Complete:
  - retired_count += 1, wrapping modulo 2^COUNT_WIDTH.
  - Next state is HALT if the latched stop_bit = 1, otherwise FETCH.
- HALT: start=1 -> FETCH; retired_count is held.
- ERROR: sticky until reset. start is ignored.
- start is ignored in FETCH through WRITE_BACK.
- Cycle counts per instruction:
  - J-type = 2.
  - BEQ = 3.
  - ALU class = 4.
  - SW = 4 + waits.
  - LW = 5 + waits.
  - "Waits" = cycles with mem_ready low; zero-wait memory means 1 MEMORY cycle.
- Exactly one en_* is high in every active state. All are low in IDLE, HALT and ERROR.

Decomposition:
- Package risc_pkg holds the shared constants:
  - type codes: R=2'b00, J=2'b01, I=2'b10, S=2'b11
  - I-type function codes: ANDI=0, ADDI=1, LW=2, SW=3, BEQ=4
  - legal function ranges: R 0-3, J 0-2, S 0-3; every other code is illegal
  - state encoding and class enum (JUMP, BRANCH, ALU, LOAD, STORE, ILLEGAL)
- Sub-module instr_class_decode: purely combinational, maps type and function to class.

Test Plan:
- Reset, then start pulse with R-type ADD (00, fn 1, stop 0) -> enables pulse F,D,E,WB on cycles 1-4 after start; retired_count=1 on cycle 5, FETCH re-entered.
- LW (10, fn 2) with mem_ready low 3 cycles then high -> mem_req high 4 cycles, mem_write=0, then WRITE_BACK; total 8 cycles; count +1.
- SW (10, fn 3), mem_ready never high, MEM_TIMEOUT=16 -> ERROR after 16 MEMORY cycles, mem_timeout=1, mem_req=0, count unchanged; later start ignored.
- Sequence J (01, fn 0) then BEQ (10, fn 4) with stop_bit=1 on BEQ -> 2 + 3 cycles, halted=1, count=2; start -> FETCH resumes.
- Illegal type I, fn 31 -> ERROR after DECODE, illegal_instr=1, no EXECUTE pulse.
- Assert reset mid-MEMORY of an LW -> same-cycle (async) drop of mem_req and en_memory, state IDLE, count=0; COUNT_WIDTH=4 run of 17 instructions -> count wraps to 1.
